input_16: RTL and testbench
===========================

Name: input_16

Overview:
- Receive-side counterpart of the 16-bit result serializer on the 10-bit chip I/O bus.
- Accepts byte beats on data_in, where data_in[9:2] is the byte and data_in[1:0] is the marker.
- Reassembles NUM_OPS 16-bit operands, sent high byte first, then low byte.
- Hands the completed operand set to the calculator with a single-cycle start_calc pulse, holding the frame while the calculator is busy.

Parameters:
- NUM_OPS, 2: number of 16-bit operands per frame; legal range 1..4.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  10  [9:2] = byte; [1:0] = marker: 2'b11 data, 2'b01 abort, 2'b00/2'b10 idle.
- calc_busy  input  1  calculator busy; start_calc is never issued while high.
- operands  output  NUM_OPS*16  operand k in bits [16k+15:16k]; operand 0 is received first.
- start_calc  output  1  one-cycle pulse; operands valid from this cycle until the next frame completes.
- frame_err  output  1  one-cycle pulse on a framing error.
- overrun  output  1  sticky; set when a data beat arrives while a frame is pending; cleared by reset only.

Behaviour:
- Reset (reset low, asynchronous): operands=0, start_calc=0, frame_err=0, overrun=0, state=IDLE, op_idx=0, pending=0.
- A beat is a data beat iff data_in[1:0]==2'b11. The byte is registered on that edge.
- FSM states: IDLE, LO, PEND.
- IDLE:
  - On a data beat: shadow_hi <= byte, then go to LO.
  - On any other marker: stay in IDLE.
- LO:
  - Data beat: shadow operand[op_idx] <= {shadow_hi, byte}.
    - If op_idx==NUM_OPS-1: go to PEND, op_idx <= 0.
    - Otherwise: op_idx++ and go to IDLE.
  - Non-data beat: pulse frame_err next cycle, discard the partial frame (op_idx <= 0), go to IDLE.
  - The high and low bytes must therefore be on back-to-back cycles, matching the transmit side.
- Gaps (idle beats) between operands are allowed. The whole frame is not time-limited.
- Abort (2'b01) in any state except PEND: discard the partial frame, op_idx <= 0, go to IDLE. No frame_err pulse.
- PEND:
  - If calc_busy==0 on this edge: copy shadow to operands, pulse start_calc for 1 cycle, go to IDLE.
  - If calc_busy==1: wait.
  - Latency from the last low-byte edge to start_calc high is one cycle when calc_busy is low.
  - Any data beat while in PEND is dropped and sets overrun. Abort in PEND is ignored.
- The operands output register changes only on the start_calc cycle. It is stable while the calculator works on it.
- Simultaneous events:
  - calc_busy falling on the same edge the last low byte arrives: the frame goes to PEND first and is released on the following edge.
  - A data beat arriving on the cycle start_calc pulses is accepted as a new high byte in IDLE, with no overrun.
- Reset asserted mid-frame or in PEND: everything clears immediately. No start_calc is issued after reset releases.
- NUM_OPS==1: the frame completes after a single high/low pair.

Test Plan:
- NUM_OPS=2, calc_busy=0:
  - Stimulus: beats 0x12/11, 0x34/11, idle, 0xAB/11, 0xCD/11.
  - Required: start_calc pulses exactly one cycle after the 0xCD edge; operands={16'hABCD,16'h1234}; frame_err=0.
- Broken pair:
  - Stimulus: 0x12/11, then an idle beat, then 0x34/11 and 0x56/11 ... a full clean frame.
  - Required: frame_err pulses once; the first operand of the clean frame is 0x3456; start_calc pulses once.
- Busy hold:
  - Stimulus: a complete frame while calc_busy=1 for 5 cycles; one data beat during the wait.
  - Required: no start_calc during busy; start_calc on the first edge with busy low; operands match the frame; overrun=1 and stays 1.
- Abort:
  - Stimulus: 0x12/11, 0x34/11, abort beat (marker 2'b01), then a full frame 0x00 0x01 0x00 0x02.
  - Required: operands={16'h0002,16'h0001}; no frame_err; exactly one start_calc.
- Async reset:
  - Stimulus: reset low for half a cycle while in LO and again while in PEND.
  - Required: all outputs 0 immediately; no start_calc after release; the next clean frame is received correctly.
- Back-to-back frames:
  - Stimulus: the first byte of frame 2 arrives on the start_calc cycle of frame 1.
  - Required: both frames are delivered with two start_calc pulses and overrun=0.

Source files
------------

// File: rtl/input_16_if.sv
// Bus between the 10-bit chip I/O receiver and the calculator.
// The receiver (input_16) takes the slave side; the stimulus side
// (transmit link plus calculator) takes the master side.
interface input_16_if #(
   parameter int unsigned NUM_OPS = 2
);
   logic [9:0]           data_in;
   logic                 calc_busy;
   logic [NUM_OPS*16-1:0] operands;
   logic                 start_calc;
   logic                 frame_err;
   logic                 overrun;

   modport master (
      output data_in,
      output calc_busy,
      input  operands,
      input  start_calc,
      input  frame_err,
      input  overrun
   );

   modport slave (
      input  data_in,
      input  calc_busy,
      output operands,
      output start_calc,
      output frame_err,
      output overrun
   );
endinterface

// File: rtl/input_16.sv
// Receive-side operand deframer for the 10-bit chip I/O bus.
// Each beat carries a byte in data_in[9:2] and a marker in data_in[1:0]
// (11 = data, 01 = abort, 00/10 = idle). NUM_OPS 16-bit operands arrive
// high byte then low byte on back-to-back cycles; a completed set is held
// until the calculator is free, then released with a one-cycle start_calc.
// Legal NUM_OPS range is 1..4 (op_idx is two bits wide).
module input_16 #(
   parameter int unsigned NUM_OPS = 2
) (
   input logic       clock,
   input logic       reset,
   input_16_if.slave bus
);

   localparam int unsigned W        = NUM_OPS * 16;
   localparam logic [1:0]  LAST_IDX = 2'(NUM_OPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t         state;
   logic [1:0]     op_idx;
   logic [7:0]     shadow_hi;
   logic [W-1:0]   shadow;
   logic [W-1:0]   operands;
   logic           start_calc;
   logic           frame_err;
   logic           overrun;

   logic [7:0]     beat_byte;
   logic           is_data;
   logic           is_abort;

   assign beat_byte = bus.data_in[9:2];
   assign is_data   = (bus.data_in[1:0] == 2'b11);
   assign is_abort  = (bus.data_in[1:0] == 2'b01);

   assign bus.operands   = operands;
   assign bus.start_calc = start_calc;
   assign bus.frame_err  = frame_err;
   assign bus.overrun    = overrun;

   // Frame FSM: assembles operands into the shadow set, releases it to the
   // operands register when the calculator is idle, and flags errors.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         op_idx     <= '0;
         shadow_hi  <= '0;
         shadow     <= '0;
         operands   <= '0;
         start_calc <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         start_calc <= 1'b0;
         frame_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (is_data) begin
                  shadow_hi <= beat_byte;
                  state     <= LO;
               end else if (is_abort) begin
                  op_idx <= '0;
               end
            end
            LO: begin
               if (is_data) begin
                  for (int unsigned k = 0; k < NUM_OPS; k++) begin
                     if (op_idx == 2'(k)) begin
                        shadow[k*16 +: 16] <= {shadow_hi, beat_byte};
                     end
                  end
                  if (op_idx == LAST_IDX) begin
                     op_idx <= '0;
                     state  <= PEND;
                  end else begin
                     op_idx <= op_idx + 2'd1;
                     state  <= IDLE;
                  end
               end else begin
                  // Abort drops the frame silently; any other gap splits a
                  // high/low pair and is reported as a framing error.
                  frame_err <= !is_abort;
                  op_idx    <= '0;
                  state     <= IDLE;
               end
            end
            PEND: begin
               // Data here has nowhere to go; aborts are deliberately ignored
               // so a completed frame is never lost.
               if (is_data) begin
                  overrun <= 1'b1;
               end
               if (!bus.calc_busy) begin
                  operands   <= shadow;
                  start_calc <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               op_idx <= '0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_16.sv
// Self-checking bench for input_16: directed frames from the test plan plus
// randomized beats, checked by a scoreboard against a byte-queue model.
module tb_input_16;

   localparam int unsigned N = 2;
   localparam int unsigned W = N * 16;

   logic clock = 1'b0;
   logic reset = 1'b1;

   input_16_if #(.NUM_OPS(N)) bus ();

   input_16 #(.NUM_OPS(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned  cyc;
      logic [W-1:0] ops;
   } start_t;

   // Scoreboard queues: expected start_calc events and frame_err cycles.
   start_t      sc_q[$];
   int unsigned ferr_q[$];

   // Reference model: bytes of the frame collected so far, plus a held frame.
   logic [7:0]   m_bytes[$];
   bit           m_pend = 1'b0;
   logic [W-1:0] m_ops  = '0;
   bit           m_ovr  = 1'b0;

   logic [W-1:0] cur_ops = '0;
   int unsigned  cyc     = 0;
   int unsigned  checks  = 0;
   int unsigned  errors  = 0;
   bit           exp_s;
   bit           exp_f;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Predict the effect of the beat sampled at the next rising edge.
   task automatic model_step(input logic [1:0] m, input logic [7:0] b, input logic busy);
      int unsigned e;
      start_t      s;
      e = cyc + 1;
      if (m_pend) begin
         if (m == 2'b11) m_ovr = 1'b1;
         if (!busy) begin
            s.cyc = e;
            s.ops = m_ops;
            sc_q.push_back(s);
            m_pend = 1'b0;
         end
      end else if (m == 2'b11) begin
         m_bytes.push_back(b);
         if (m_bytes.size() == int'(2 * N)) begin
            m_ops = '0;
            for (int k = 0; k < int'(N); k++)
               m_ops[16*k +: 16] = {m_bytes[2*k], m_bytes[2*k+1]};
            m_pend = 1'b1;
            m_bytes.delete();
         end
      end else begin
         if ((m_bytes.size() % 2) == 1 && m != 2'b01) ferr_q.push_back(e);
         if ((m_bytes.size() % 2) == 1 || m == 2'b01) m_bytes.delete();
      end
   endtask

   task automatic beat(input logic [1:0] m, input logic [7:0] b, input logic busy);
      @(negedge clock);
      bus.data_in   = {b, m};
      bus.calc_busy = busy;
      model_step(m, b, busy);
   endtask

   task automatic d(input logic [7:0] b, input logic busy = 1'b0);
      beat(2'b11, b, busy);
   endtask

   task automatic idle(input int n, input logic busy = 1'b0);
      for (int i = 0; i < n; i++) beat(2'b00, 8'h00, busy);
   endtask

   // Assert reset for half a cycle, away from the rising edge.
   task automatic do_reset();
      @(posedge clock);
      #2;
      reset         = 1'b0;
      bus.data_in   = '0;
      bus.calc_busy = 1'b0;
      m_bytes.delete();
      m_pend  = 1'b0;
      m_ovr   = 1'b0;
      cur_ops = '0;
      #1;
      check("rst_operands", bus.operands, '0);
      check("rst_start_calc", W'(bus.start_calc), '0);
      check("rst_frame_err", W'(bus.frame_err), '0);
      check("rst_overrun", W'(bus.overrun), '0);
      @(negedge clock);
      reset = 1'b1;
      model_step(2'b00, 8'h00, 1'b0);
   endtask

   // Monitor: compares every output each cycle against the scoreboard.
   always @(posedge clock) begin
      cyc++;
      #1;
      exp_s = (sc_q.size() > 0) && (sc_q[0].cyc == cyc);
      check("start_calc", W'(bus.start_calc), W'(exp_s));
      if (exp_s) begin
         cur_ops = sc_q[0].ops;
         void'(sc_q.pop_front());
      end
      exp_f = (ferr_q.size() > 0) && (ferr_q[0] == cyc);
      check("frame_err", W'(bus.frame_err), W'(exp_f));
      if (exp_f) void'(ferr_q.pop_front());
      check("operands", bus.operands, cur_ops);
      check("overrun", W'(bus.overrun), W'(m_ovr));
   end

   initial begin
      logic [1:0] m;
      logic       busy;
      int unsigned r;

      bus.data_in   = '0;
      bus.calc_busy = 1'b0;
      #1 reset = 1'b0;
      #1;
      check("init_operands", bus.operands, '0);
      check("init_start_calc", W'(bus.start_calc), '0);
      check("init_frame_err", W'(bus.frame_err), '0);
      check("init_overrun", W'(bus.overrun), '0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Basic frame with a gap between operands.
      d(8'h12); d(8'h34); idle(1); d(8'hAB); d(8'hCD); idle(3);
      check("basic_operands", bus.operands, W'(32'hABCD_1234));

      // Broken pair followed by a clean frame.
      d(8'h12); idle(1); d(8'h34); d(8'h56); d(8'h78); d(8'h9A); idle(3);
      check("broken_operands", bus.operands, W'(32'h789A_3456));

      // Abort mid-frame, then a clean frame.
      d(8'h12); d(8'h34); beat(2'b01, 8'h00, 1'b0);
      d(8'h00); d(8'h01); d(8'h00); d(8'h02); idle(3);
      check("abort_operands", bus.operands, W'(32'h0002_0001));

      // Back-to-back: frame 2 high byte lands on frame 1's start_calc cycle.
      d(8'h11); d(8'h22); d(8'h33); d(8'h44); idle(1);
      d(8'h55); d(8'h66); d(8'h77); d(8'h88); idle(3);
      check("b2b_operands", bus.operands, W'(32'h7788_5566));
      check("b2b_overrun", W'(bus.overrun), '0);

      // Busy hold with a data beat arriving while the frame is pending.
      d(8'hC1, 1'b1); d(8'hC2, 1'b1); d(8'hC3, 1'b1); d(8'hC4, 1'b1);
      idle(2, 1'b1); d(8'hEE, 1'b1); idle(1, 1'b1); idle(4, 1'b0);
      check("busy_operands", bus.operands, W'(32'hC3C4_C1C2));
      check("busy_overrun", W'(bus.overrun), W'(1'b1));

      // Randomized beats and busy pattern.
      busy = 1'b0;
      repeat (800) begin
         r = $urandom_range(0, 9);
         m = (r < 6) ? 2'b11 : (r < 7) ? 2'b01 : (r < 9) ? 2'b00 : 2'b10;
         if ($urandom_range(0, 5) == 0) busy = ~busy;
         beat(m, 8'($urandom), busy);
      end
      idle(3, 1'b0);

      // Reset in LO, then in PEND, then a clean frame.
      d(8'h12);
      do_reset();
      idle(2);
      d(8'hA1, 1'b1); d(8'hA2, 1'b1); d(8'hA3, 1'b1); d(8'hA4, 1'b1); idle(1, 1'b1);
      do_reset();
      idle(4);
      d(8'h5A); d(8'hA5); d(8'h0F); d(8'hF0); idle(3);
      check("post_reset_operands", bus.operands, W'(32'h0FF0_5AA5));

      idle(3);
      check("queues_drained", W'(sc_q.size() + ferr_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
